// File: rtl/rom_arbiter_pkg.sv
// rom_arbiter_pkg: shared constants for the two-port ROM arbiter.
// Owner encoding of the in-flight read and starvation-counter width.
package rom_arbiter_pkg;

  localparam int RUN_W = 8;

  typedef logic [RUN_W-1:0] run_cnt_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_A    = 2'd1;
  localparam logic [1:0] OWN_B    = 2'd2;

endpackage

// File: rtl/rom_arb_starve_ctr.sv
// rom_arb_starve_ctr: counts A grants that overtake a waiting B.
// Raises force_b once the run reaches MAX_A_RUN so B gets a slot.
module rom_arb_starve_ctr
  import rom_arbiter_pkg::*;
#(
  parameter int MAX_A_RUN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic a_gnt,
  input  logic b_gnt,
  input  logic b_req,
  output logic force_b
);

  localparam run_cnt_t C_MAX = run_cnt_t'(MAX_A_RUN);

  run_cnt_t r_run_cnt;

  // saturating run of A grants while B waits; any B grant or idle B clears
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_run_cnt <= '0;
    end else if (b_gnt || !b_req) begin
      r_run_cnt <= '0;
    end else if (a_gnt && (r_run_cnt < C_MAX)) begin
      r_run_cnt <= r_run_cnt + 1'b1;
    end
  end

  assign force_b = b_req & (r_run_cnt == C_MAX);

endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one registered-address ROM between a high
// priority requester A and a low priority requester B.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int AW        = 14,
  parameter int DW        = 8,
  parameter int MAX_A_RUN = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic [AW-1:0] a_addr,
  output logic          a_gnt,
  output logic          a_rvalid,
  input  logic          b_req,
  input  logic [AW-1:0] b_addr,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] rdata,
  output logic          rom_ce,
  output logic          rom_oe,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_dout
);

  logic       w_force_b;
  logic       w_a_gnt;
  logic       w_b_gnt;
  logic       w_live;
  logic [1:0] r_owner;

  rom_arb_starve_ctr #(
    .MAX_A_RUN (MAX_A_RUN)
  ) u_ctr (
    .clk     (clk),
    .rst     (rst),
    .a_gnt   (w_a_gnt),
    .b_gnt   (w_b_gnt),
    .b_req   (b_req),
    .force_b (w_force_b)
  );

  assign w_a_gnt = rst & a_req & ~w_force_b;
  assign w_b_gnt = rst & b_req & (~a_req | w_force_b);

  assign a_gnt    = w_a_gnt;
  assign b_gnt    = w_b_gnt;
  assign rom_ce   = w_a_gnt | w_b_gnt;
  assign rom_addr = w_b_gnt ? b_addr : a_addr;

  // remember who owns the read issued this cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_owner <= OWN_NONE;
    end else begin
      unique case (1'b1)
        w_a_gnt: r_owner <= OWN_A;
        w_b_gnt: r_owner <= OWN_B;
        default: r_owner <= OWN_NONE;
      endcase
    end
  end

  assign w_live = rst & (r_owner != OWN_NONE);
  assign rom_oe = w_live;

  // route returning ROM data to its owner; quiet bus otherwise
  always_comb begin
    a_rvalid = 1'b0;
    b_rvalid = 1'b0;
    rdata    = '0;
    if (w_live) begin
      rdata = rom_dout;
      unique case (1'b1)
        (r_owner == OWN_A): a_rvalid = 1'b1;
        (r_owner == OWN_B): b_rvalid = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: two arbiters (MAX_A_RUN 4 and 1) against a
// behavioural model, plus directed literal checks.
module tb_rom_arbiter;

  logic             clk;
  logic             rst;
  logic [1:0]       a_req, b_req;
  logic [1:0][13:0] a_addr, b_addr;
  logic [1:0]       a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [1:0]       rom_ce, rom_oe;
  logic [1:0][13:0] rom_addr, rom_q;
  logic [1:0][7:0]  rdata, rom_dout;

  logic [7:0] mem [0:16383];

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  int MAXR [2] = '{4, 1};
  int m_run[2] = '{0, 0};
  int m_own[2] = '{0, 0};
  logic [13:0] m_adr[2];
  logic [1:0] gl_a = '0;
  logic [1:0] gl_b = '0;

  rom_arbiter #(.AW(14), .DW(8), .MAX_A_RUN(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .a_req(a_req[0]), .a_addr(a_addr[0]),
    .a_gnt(a_gnt[0]), .a_rvalid(a_rvalid[0]),
    .b_req(b_req[0]), .b_addr(b_addr[0]),
    .b_gnt(b_gnt[0]), .b_rvalid(b_rvalid[0]),
    .rdata(rdata[0]), .rom_ce(rom_ce[0]),
    .rom_oe(rom_oe[0]), .rom_addr(rom_addr[0]),
    .rom_dout(rom_dout[0])
  );

  rom_arbiter #(.AW(14), .DW(8), .MAX_A_RUN(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .a_req(a_req[1]), .a_addr(a_addr[1]),
    .a_gnt(a_gnt[1]), .a_rvalid(a_rvalid[1]),
    .b_req(b_req[1]), .b_addr(b_addr[1]),
    .b_gnt(b_gnt[1]), .b_rvalid(b_rvalid[1]),
    .rdata(rdata[1]), .rom_ce(rom_ce[1]),
    .rom_oe(rom_oe[1]), .rom_addr(rom_addr[1]),
    .rom_dout(rom_dout[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ROM models: address register loaded on ce, data one cycle later
  always @(posedge clk) begin
    if (rom_ce[0]) rom_q[0] <= rom_addr[0];
    if (rom_ce[1]) rom_q[1] <= rom_addr[1];
  end
  assign rom_dout[0] = mem[rom_q[0]];
  assign rom_dout[1] = mem[rom_q[1]];

  // requesters must hold req and address until granted
  ap_a0: assert property (@(posedge clk) disable iff (!rst)
    (a_req[0] && !a_gnt[0]) |=> (a_req[0] && $stable(a_addr[0])));
  ap_b0: assert property (@(posedge clk) disable iff (!rst)
    (b_req[0] && !b_gnt[0]) |=> (b_req[0] && $stable(b_addr[0])));
  ap_a1: assert property (@(posedge clk) disable iff (!rst)
    (a_req[1] && !a_gnt[1]) |=> (a_req[1] && $stable(a_addr[1])));
  ap_b1: assert property (@(posedge clk) disable iff (!rst)
    (b_req[1] && !b_gnt[1]) |=> (b_req[1] && $stable(b_addr[1])));

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_s(input string name,
                       input string act,
                       input string exp);
    n_chk++;
    if (act == exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $display("FAIL %s: got %s expected %s", name, act, exp);
    end
  endtask

  // spec-level model: grant choice, starvation streak, one-deep return
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic        f, ea, eb, live;
      logic [13:0] ead;
      logic [7:0]  erd;
      logic [27:0] ev, av;
      f    = b_req[i] && (m_run[i] >= MAXR[i]);
      ea   = rst && a_req[i] && !f;
      eb   = rst && b_req[i] && (!a_req[i] || f);
      ead  = eb ? b_addr[i] : a_addr[i];
      live = rst && (m_own[i] != 0);
      erd  = live ? mem[m_adr[i]] : 8'h00;
      ev = {ea, eb, ea | eb, live,
            live && m_own[i] == 1, live && m_own[i] == 2, ead, erd};
      av = {a_gnt[i], b_gnt[i], rom_ce[i], rom_oe[i],
            a_rvalid[i], b_rvalid[i], rom_addr[i], rdata[i]};
      chk(i == 0 ? "cyc_max4" : "cyc_max1", 32'(av), 32'(ev));
      gl_a[i] = a_gnt[i];
      gl_b[i] = b_gnt[i];
      if (!rst) begin
        m_run[i] = 0;
        m_own[i] = 0;
      end else begin
        if (ea && b_req[i])
          m_run[i] = (m_run[i] < MAXR[i]) ? m_run[i] + 1 : m_run[i];
        else
          m_run[i] = 0;
        m_own[i] = ea ? 1 : (eb ? 2 : 0);
        m_adr[i] = ead;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drop each request only in the cycle after it was granted
  task automatic release_all();
    int n;
    logic [1:0] ga, gb;
    n = 0;
    while (((a_req | b_req) != 2'b00) && n < 12) begin
      @(negedge clk);
      ga = a_gnt;
      gb = b_gnt;
      tick();
      a_req = a_req & ~ga;
      b_req = b_req & ~gb;
      n++;
    end
    chk("release", 32'(a_req | b_req), 32'h0);
  endtask

  string pat4, pat1;

  initial begin
    for (int k = 0; k < 16384; k++)
      mem[k] = 8'((k * 29) ^ (k >> 6) ^ 8'h5A);
    mem[0] = 8'hF3;
    for (int k = 16'h3D00; k < 16'h3D08; k++)
      mem[k] = 8'h00;

    rst    = 1'b0;
    a_req  = 2'b11;
    a_addr = '0;
    b_req  = 2'b00;
    b_addr = '0;

    // reset with A requesting: nothing granted, bus quiet
    repeat (3) begin
      @(negedge clk);
      chk("rst_idle", 32'({a_gnt, rom_ce, rdata}), 32'h0);
      tick();
    end
    rst = 1'b1;
    @(negedge clk);
    chk("first_gnt", 32'(a_gnt), 32'h3);
    tick();
    a_req = 2'b00;
    @(negedge clk);
    chk("first_rv", 32'(a_rvalid), 32'h3);
    chk("first_rd", 32'(rdata[0]), 32'hF3);
    tick();

    // A streaming 0..7, pipelined returns
    for (int k = 0; k < 9; k++) begin
      if (k < 8) begin
        a_req  = 2'b11;
        a_addr = {14'(k), 14'(k)};
      end else begin
        a_req = 2'b00;
      end
      @(negedge clk);
      if (k < 8) chk("stream_gnt", 32'(a_gnt), 32'h3);
      if (k > 0) begin
        chk("stream_rv", 32'(a_rvalid), 32'h3);
        chk("stream_rd", 32'(rdata[0]), 32'(mem[k-1]));
      end
      tick();
    end

    // continuous dual requests: starvation guard pattern
    a_req  = 2'b11;
    b_req  = 2'b11;
    a_addr = {14'h0100, 14'h0100};
    b_addr = {14'h3D00, 14'h3D00};
    pat4 = "";
    pat1 = "";
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      pat4 = {pat4, a_gnt[0] ? "A" : (b_gnt[0] ? "B" : "-")};
      pat1 = {pat1, a_gnt[1] ? "A" : (b_gnt[1] ? "B" : "-")};
      if (c == 5) begin
        chk("max4_brv", 32'({a_rvalid[0], b_rvalid[0]}), 32'h1);
        chk("max4_brd", 32'(rdata[0]), 32'h00);
      end
      if (c == 2) begin
        chk("max1_brv", 32'({a_rvalid[1], b_rvalid[1]}), 32'h1);
        chk("max1_brd", 32'(rdata[1]), 32'h00);
      end
      if (c == 3) begin
        chk("max1_arv", 32'({a_rvalid[1], b_rvalid[1]}), 32'h2);
        chk("max1_ard", 32'(rdata[1]), 32'(mem[16'h0100]));
      end
      tick();
    end
    chk_s("pat_max4", pat4, "AAAABAAAAB");
    chk_s("pat_max1", pat1, "ABABABABAB");
    release_all();

    // B alone: granted at once, data next cycle
    b_req  = 2'b11;
    b_addr = {14'h3D08, 14'h3D08};
    @(negedge clk);
    chk("b_only_gnt", 32'({a_gnt, b_gnt}), 32'h3);
    tick();
    b_req = 2'b00;
    @(negedge clk);
    chk("b_only_rv", 32'({a_rvalid, b_rvalid}), 32'h3);
    chk("b_only_rd", 32'(rdata[0]), 32'(mem[16'h3D08]));
    tick();

    // grant then reset: the in-flight read is dropped
    a_req  = 2'b11;
    a_addr = {14'h0010, 14'h0010};
    @(negedge clk);
    chk("drop_gnt", 32'(a_gnt), 32'h3);
    tick();
    a_req = 2'b00;
    rst   = 1'b0;
    @(negedge clk);
    chk("drop_rv", 32'({a_rvalid, rom_oe}), 32'h0);
    chk("drop_rd", 32'(rdata), 32'h0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("drop_after", 32'(a_rvalid), 32'h0);
    tick();
    a_req = 2'b11;
    @(negedge clk);
    chk("refetch_gnt", 32'(a_gnt), 32'h3);
    tick();
    a_req = 2'b00;
    @(negedge clk);
    chk("refetch_rv", 32'(a_rvalid), 32'h3);
    chk("refetch_rd", 32'(rdata[1]), 32'(mem[16]));
    tick();

    // random traffic with occasional resets
    repeat (3000) begin
      rst = ($urandom_range(0, 99) >= 3);
      for (int i = 0; i < 2; i++) begin
        if (!a_req[i] || gl_a[i]) begin
          a_req[i]  = ($urandom_range(0, 9) < 8);
          a_addr[i] = 14'($urandom);
        end
        if (!b_req[i] || gl_b[i]) begin
          b_req[i]  = ($urandom_range(0, 9) < 5);
          b_addr[i] = 14'($urandom);
        end
      end
      @(negedge clk);
      tick();
    end
    rst = 1'b1;
    release_all();
    @(negedge clk);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
